// File: rtl/tdc_cali_ctrl_if.sv
// tdc_cali_ctrl_if: control/histogram bundle of the TDC calibration sequencer.
// Optional auto-recalibration lives in the sequencer (CALI_AUTO_RESTART_EN).
interface tdc_cali_ctrl_if #(
  parameter int BIN_W = 8
);
  logic             i_start;
  logic             i_locked;
  logic             i_hit_valid;
  logic [BIN_W-1:0] i_bin;
  logic             o_control;
  logic             o_cali_mode;
  logic             o_hist_we;
  logic             o_hist_clr;
  logic [BIN_W-1:0] o_hist_addr;
  logic             o_busy;
  logic             o_done;
  logic             o_timeout;

  modport master (
    output i_start, i_locked, i_hit_valid, i_bin,
    input  o_control, o_cali_mode, o_hist_we, o_hist_clr,
    input  o_hist_addr, o_busy, o_done, o_timeout
  );

  modport slave (
    input  i_start, i_locked, i_hit_valid, i_bin,
    output o_control, o_cali_mode, o_hist_we, o_hist_clr,
    output o_hist_addr, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/tdc_cali_ctrl.sv
// tdc_cali_ctrl: clear histogram, run cali clock, wait lock, settle, collect hits.
// Define CALI_AUTO_RESTART_EN to recalibrate RECAL_PERIOD cycles after DONE.
module tdc_cali_ctrl #(
  parameter int BIN_W         = 8,
  parameter int HIT_W         = 16,
  parameter int N_HITS        = 10000,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64
`ifdef CALI_AUTO_RESTART_EN
  ,
  parameter int RECAL_PERIOD  = 1 << 24
`endif
) (
  input logic           i_clk,
  input logic           i_reset_n,
  tdc_cali_ctrl_if.slave cif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_LOCK,
    S_SETTLE,
    S_COLLECT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [BIN_W-1:0] ADDR_LAST = '1;
  localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(N_HITS - 1);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  state_t           state;
  logic [1:0]       lk_sync;
  logic             lock;
  logic [15:0]      cnt;
  logic [HIT_W-1:0] hits;
  logic             go;

  assign lock = lk_sync[1];

  // two-flop synchroniser for the asynchronous MMCM lock
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) lk_sync <= 2'b00;
    else            lk_sync <= {lk_sync[0], cif.i_locked};
  end

`ifdef CALI_AUTO_RESTART_EN
  localparam int RC_W = (RECAL_PERIOD > 1) ? $clog2(RECAL_PERIOD) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECAL_PERIOD - 1);

  logic [RC_W-1:0] rc;
  logic            auto_go;

  assign auto_go = (state == S_DONE) && (rc == RC_LAST);
  assign go      = cif.i_start | auto_go;

  // idle timer in DONE; restarts from zero on every DONE entry
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)          rc <= '0;
    else if (state != S_DONE) rc <= '0;
    else if (rc != RC_LAST)   rc <= rc + 1'b1;
  end
`else
  assign go = cif.i_start;
`endif

  // sequencer state plus all registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      hits            <= '0;
      cif.o_control   <= 1'b0;
      cif.o_cali_mode <= 1'b0;
      cif.o_hist_we   <= 1'b0;
      cif.o_hist_clr  <= 1'b0;
      cif.o_hist_addr <= '0;
      cif.o_busy      <= 1'b0;
      cif.o_done      <= 1'b0;
      cif.o_timeout   <= 1'b0;
    end else begin
      cif.o_hist_we   <= 1'b0;
      cif.o_control   <= state inside {S_WAIT_LOCK, S_SETTLE, S_COLLECT};
      cif.o_cali_mode <= state inside {S_SETTLE, S_COLLECT};
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go) begin
            state           <= S_CLEAR;
            cnt             <= '0;
            hits            <= '0;
            cif.o_busy      <= 1'b1;
            cif.o_done      <= 1'b0;
            cif.o_timeout   <= 1'b0;
            cif.o_hist_we   <= 1'b1;
            cif.o_hist_clr  <= 1'b1;
            cif.o_hist_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (cif.o_hist_addr == ADDR_LAST) begin
            state          <= S_WAIT_LOCK;
            cif.o_hist_clr <= 1'b0;
          end else begin
            cif.o_hist_we   <= 1'b1;
            cif.o_hist_addr <= cif.o_hist_addr + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            state         <= S_ERROR;
            cif.o_busy    <= 1'b0;
            cif.o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SETTLE: begin
          if (!lock) begin
            state         <= S_ERROR;
            cif.o_busy    <= 1'b0;
            cif.o_timeout <= 1'b1;
          end else if (cnt == SET_LAST) begin
            state <= S_COLLECT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_COLLECT: begin
          if (cif.i_hit_valid) begin
            cif.o_hist_we   <= 1'b1;
            cif.o_hist_clr  <= 1'b0;
            cif.o_hist_addr <= cif.i_bin;
            hits <= (hits == HIT_MAX) ? hits : hits + 1'b1;
          end
          // the final hit wins over a simultaneous lock loss
          if (cif.i_hit_valid && hits == HIT_LAST) begin
            state      <= S_DONE;
            cif.o_busy <= 1'b0;
            cif.o_done <= 1'b1;
          end else if (!lock) begin
            state         <= S_ERROR;
            cif.o_busy    <= 1'b0;
            cif.o_timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
